spi_arb: RTL

- Schedules a single shared SPI master between two requesters in the QuadCopter: the inertial interface (inertial sensor, requester 0) and the battery monitor (ADC128S A2D, requester 1).
- Grants one 16-bit transaction at a time and routes the master's SS_n to the selected slave.
- Returns read data and a done pulse to the winning requester.
- Gives inertial priority, with streak-limited fairness so battery reads cannot starve.

---
 rtl/spi_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/spi_arb.sv
// Arbitrates one shared SPI master between the inertial interface (req 0) and the
// battery A2D (req 1): inertial priority, streak-limited so battery reads cannot starve.
module spi_arb #(
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_done,
  input  logic        batt_req,
  input  logic [15:0] batt_cmd,
  output logic        batt_done,
  output logic [15:0] rd_data,
  output logic        err,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  input  logic        ss_mstr_n,
  output logic        ss_inert_n,
  output logic        ss_a2d_n
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t        state;
  logic          sel;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic [GW-1:0] gap_cnt;

  logic active;
  logic any_req;
  logic batt_win;
  logic finish;

  // Slave selects only follow the master while a transaction owns the bus.
  assign active     = (state == LAUNCH) || (state == BUSY);
  assign ss_inert_n = (active && !sel) ? ss_mstr_n : 1'b1;
  assign ss_a2d_n   = (active && sel)  ? ss_mstr_n : 1'b1;

  assign any_req  = inert_req | batt_req;
  assign batt_win = batt_req && (!inert_req || (streak >= STREAK_MAX));
  assign finish   = (state == BUSY) && (spi_done || (timer == TMO_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      streak     <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      spi_wrt    <= 1'b0;
      spi_cmd    <= '0;
      inert_done <= 1'b0;
      batt_done  <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
    end else begin
      spi_wrt    <= 1'b0;
      inert_done <= 1'b0;
      batt_done  <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            sel     <= batt_win;
            spi_cmd <= batt_win ? batt_cmd : inert_cmd;
            timer   <= '0;
            spi_wrt <= 1'b1;
            state   <= LAUNCH;
            // Streak counts inertial wins taken while battery was left waiting.
            if (!batt_win && batt_req) begin
              if (streak != STREAK_MAX) streak <= streak + SW'(1);
            end else begin
              streak <= '0;
            end
          end
        end
        LAUNCH: begin
          timer <= timer + TW'(1);
          state <= BUSY;
        end
        BUSY: begin
          timer <= timer + TW'(1);
          if (finish) begin
            rd_data    <= spi_done ? spi_rd : 16'h0000;
            err        <= !spi_done;
            inert_done <= !sel;
            batt_done  <= sel;
            gap_cnt    <= '0;
            state      <= (GAP_CYC == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
